// File: rtl/sdff_bank_bist_if.sv
// Stimulus/response bus between the BIST and the 12-flop sync-reset bank.
// The master drives D/E/RS and reads the bank's Q.
interface sdff_bank_bist_if;
   logic        D;
   logic        E;
   logic [3:0]  RS;
   logic [11:0] Q;

   modport master (
      output D,
      output E,
      output RS,
      input  Q
   );

   modport slave (
      input  D,
      input  E,
      input  RS,
      output Q
   );
endinterface

// File: rtl/sdff_bank_bist.sv
// LFSR-driven BIST for the SDFF/SDFFE/SDFFCE sync-reset bank with a golden model.
// Optional macro SDFF_BANK_BIST_FIRST_FAIL_EN adds first-failure capture outputs.
module sdff_bank_bist #(
   parameter int unsigned CYCLES = 1024,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic             C,
   input  logic             R,
   input  logic             start,
   sdff_bank_bist_if.master bank,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_cnt
`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
   ,
   output logic [15:0]      first_fail_cyc,
   output logic [11:0]      first_fail_vec
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [15:0] SEED_L = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LAST   = 16'(CYCLES - 1);
   localparam logic [11:0] RV     = 12'hAAA;
   localparam logic [11:0] SDFF_M = 12'h0C3;
   localparam logic [11:0] SDFE_M = 12'h30C;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        d_q, d_d;
   logic        e_q, e_d;
   logic [3:0]  rs_q, rs_d;
   logic [11:0] model_q, model_d;
   logic [15:0] err_q, err_d;
   logic        mis;

`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
   logic [15:0] ffc_q, ffc_d;
   logic [11:0] ffv_q, ffv_d;
   logic        ffs_q, ffs_d;
`endif

   function automatic logic [11:0] bank_next(
      input logic [11:0] q,
      input logic        d,
      input logic        e,
      input logic [3:0]  rs
   );
      logic [11:0] r;
      logic [11:0] n;
      r = {{2{rs[3]}}, {2{rs[2]}}, {2{rs[1]}}, {6{rs[0]}}};
      n = q;
      for (int i = 0; i < 12; i++) begin
         if (SDFF_M[i])
            n[i] = r[i] ? RV[i] : d;
         else if (SDFE_M[i])
            n[i] = r[i] ? RV[i] : (e ? d : q[i]);
         else
            n[i] = e ? (r[i] ? RV[i] : d) : q[i];
      end
      return n;
   endfunction

   // {D, E, RS}; each reset line fires on two adjacent LFSR bits (~25%)
   function automatic logic [5:0] stim(input logic [15:0] l);
      return {l[0], l[1],
              l[9] & l[8], l[7] & l[6],
              l[5] & l[4], l[3] & l[2]};
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   assign mis = ((state_q == S_RUN) || (state_q == S_DRAIN))
             && (bank.Q != model_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      d_d     = 1'b0;
      e_d     = 1'b0;
      rs_d    = 4'h0;
      model_d = bank_next(model_q, d_q, e_q, rs_q);
      err_d   = err_q;
      if (mis && (err_q != 16'hFFFF))
         err_d = err_q + 16'd1;
`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
      ffc_d = ffc_q;
      ffv_d = ffv_q;
      ffs_d = ffs_q;
      if (mis && !ffs_q) begin
         ffs_d = 1'b1;
         ffc_d = cnt_q;
         ffv_d = bank.Q ^ model_q;
      end
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_PRIME;
               cnt_d   = 16'd0;
               lfsr_d  = SEED_L;
               err_d   = 16'd0;
               e_d     = 1'b1;
               rs_d    = 4'hF;
`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
               ffc_d   = 16'd0;
               ffv_d   = 12'd0;
               ffs_d   = 1'b0;
`endif
            end
         end
         S_PRIME: begin
            model_d = RV;
            e_d     = 1'b1;
            rs_d    = 4'hF;
            if (cnt_q == 16'd1) begin
               state_d            = S_RUN;
               cnt_d              = 16'd0;
               {d_d, e_d, rs_d}   = stim(lfsr_q);
               lfsr_d             = lfsr_next(lfsr_q);
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LAST) begin
               state_d = S_DRAIN;
            end else begin
               {d_d, e_d, rs_d} = stim(lfsr_q);
               lfsr_d           = lfsr_next(lfsr_q);
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge C) begin
      if (!R) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         lfsr_q  <= SEED_L;
         d_q     <= 1'b0;
         e_q     <= 1'b0;
         rs_q    <= 4'h0;
         model_q <= RV;
         err_q   <= 16'd0;
`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
         ffc_q   <= 16'd0;
         ffv_q   <= 12'd0;
         ffs_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         d_q     <= d_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         model_q <= model_d;
         err_q   <= err_d;
`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
         ffc_q   <= ffc_d;
         ffv_q   <= ffv_d;
         ffs_q   <= ffs_d;
`endif
      end
   end

   assign bank.D  = d_q;
   assign bank.E  = e_q;
   assign bank.RS = rs_q;
   assign busy    = (state_q == S_PRIME) || (state_q == S_RUN)
                 || (state_q == S_DRAIN);
   assign done    = (state_q == S_DONE);
   assign pass    = done && (err_q == 16'd0);
   assign err_cnt = err_q;

`ifdef SDFF_BANK_BIST_FIRST_FAIL_EN
   assign first_fail_cyc = ffc_q;
   assign first_fail_vec = ffv_q;
`endif

endmodule
